// File: rtl/alu_pkg.sv
// Shared encodings for the serial-ALU arbiter: op codes, sequencer states,
// the error result word and the divide-by-zero predicate.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_OPND1  = 4'd2,
        S_OPND2  = 4'd3,
        S_OPND3  = 4'd4,
        S_WAIT   = 4'd5,
        S_RES_LO = 4'd6,
        S_DONE   = 4'd7
    } state_e;

    localparam logic [15:0] ERR_RESULT = 16'hFFFF;

    function automatic logic isDivZero(input logic [1:0] op, input logic [7:0] opb);
        return (op == OP_DIV) && (opb == 8'd0);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Client-side request/result signals and ALU byte-bus signals of the arbiter.
// The arbiter uses the slave view; whatever drives clients and the ALU uses master.
interface alu_arbiter_if;

    logic        req0;
    logic        req1;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [15:0] opa0;
    logic [15:0] opa1;
    logic [7:0]  opb0;
    logic [7:0]  opb1;
    logic        done0;
    logic        done1;
    logic [15:0] res0;
    logic [15:0] res1;
    logic        err;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_finish;
    logic        busy;
    logic        owner;

    modport slave (
        input  req0, req1, op0, op1, opa0, opa1, opb0, opb1, alu_outbus, alu_finish,
        output done0, done1, res0, res1, err, alu_start, alu_op, alu_inbus, busy, owner
    );

    modport master (
        output req0, req1, op0, op1, opa0, opa1, opb0, opb1, alu_outbus, alu_finish,
        input  done0, done1, res0, res1, err, alu_start, alu_op, alu_inbus, busy, owner
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the client that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        if (i_req[0] && i_req[1]) begin
            o_grant = ~i_last;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit serial ALU between two clients: latches a whole request at grant,
// streams operand bytes, collects the two result bytes and returns a 16-bit word.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    state_e      r_state;
    state_e      w_next;
    logic        r_owner;
    logic        r_last;
    logic        r_err;
    logic [1:0]  r_op;
    logic [15:0] r_opa;
    logic [7:0]  r_opb;
    logic [7:0]  r_resHi;
    logic [15:0] r_res0;
    logic [15:0] r_res1;
    logic [7:0]  r_wdog;

    logic        w_grant;
    logic        w_valid;
    logic [1:0]  w_selOp;
    logic [15:0] w_selOpa;
    logic [7:0]  w_selOpb;
    logic        w_divZero;
    logic        w_isDiv;
    logic        w_timeout;

    rr_arbiter2 u_rrArb (
        .i_req   ({bus.req1, bus.req0}),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_selOp   = w_grant ? bus.op1  : bus.op0;
    assign w_selOpa  = w_grant ? bus.opa1 : bus.opa0;
    assign w_selOpb  = w_grant ? bus.opb1 : bus.opb0;
    assign w_divZero = isDivZero(w_selOp, w_selOpb);
    assign w_isDiv   = (r_op == OP_DIV);
    // Watchdog value seen in the last WAIT cycle before giving up
    assign w_timeout = (r_wdog == 8'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_valid) w_next = w_divZero ? S_DONE : S_START;
            S_START:  w_next = S_OPND1;
            S_OPND1:  w_next = S_OPND2;
            S_OPND2:  w_next = w_isDiv ? S_OPND3 : S_WAIT;
            S_OPND3:  w_next = S_WAIT;
            S_WAIT: begin
                if (bus.alu_finish) begin
                    w_next = S_RES_LO;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_RES_LO: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Div sends the dividend high byte first; the last operand byte stays on the bus in WAIT
    always_comb begin
        bus.alu_inbus = 8'h00;
        case (r_state)
            S_OPND1:        bus.alu_inbus = w_isDiv ? r_opa[15:8] : r_opa[7:0];
            S_OPND2:        bus.alu_inbus = w_isDiv ? r_opa[7:0]  : r_opb;
            S_OPND3, S_WAIT: bus.alu_inbus = r_opb;
            default:        bus.alu_inbus = 8'h00;
        endcase
    end

    assign bus.alu_start = (r_state == S_START);
    assign bus.alu_op    = r_op;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.owner     = r_owner;
    assign bus.done0     = (r_state == S_DONE) && !r_owner;
    assign bus.done1     = (r_state == S_DONE) && r_owner;
    assign bus.res0      = r_res0;
    assign bus.res1      = r_res1;
    assign bus.err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_op    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_resHi <= '0;
            r_res0  <= '0;
            r_res1  <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_grant;
                        r_op    <= w_selOp;
                        r_opa   <= w_selOpa;
                        r_opb   <= w_selOpb;
                        if (w_divZero) begin
                            r_err <= 1'b1;
                            if (w_grant) r_res1 <= ERR_RESULT;
                            else         r_res0 <= ERR_RESULT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.alu_finish) begin
                        r_resHi <= bus.alu_outbus;
                        r_wdog  <= '0;
                    end else if (w_timeout) begin
                        r_wdog <= '0;
                        r_err  <= 1'b1;
                        if (r_owner) r_res1 <= ERR_RESULT;
                        else         r_res0 <= ERR_RESULT;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                S_RES_LO: begin
                    r_err <= 1'b0;
                    if (r_owner) r_res1 <= {r_resHi, bus.alu_outbus};
                    else         r_res0 <= {r_resHi, bus.alu_outbus};
                end
                S_DONE:  r_last <= r_owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural serial-ALU model, result scoreboard,
// a vector table of single operations and hand-written multi-cycle sequences.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic        client;
        logic [15:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        logic        client;
        logic [1:0]  op;
        logic [15:0] opa;
        logic [7:0]  opb;
        logic [15:0] expRes;
        logic        expErr;
        int          expStarts;
        int          nBytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    alu_arbiter_if bus ();

    alu_arbiter #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t expQ[$];
    exp_t monExp;
    vec_t vecs[8];

    // ALU model state
    logic        aluHang = 1'b0;
    int          mState = 0;
    int          mCnt = 0;
    int          mNeed = 0;
    int          mDelay = 0;
    int          startCount = 0;
    int          lastCount = 0;
    logic [1:0]  mOp = 2'b00;
    logic [7:0]  lastBytes [3];
    logic [15:0] mRes = 16'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic c, input logic [1:0] op, input logic [15:0] opa,
                                   input logic [7:0] opb, input logic [15:0] r, input logic e,
                                   input int starts, input int nb, input logic [7:0] b0,
                                   input logic [7:0] b1, input logic [7:0] b2);
        vec_t v;
        v.client = c; v.op = op; v.opa = opa; v.opb = opb; v.expRes = r; v.expErr = e;
        v.expStarts = starts; v.nBytes = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        return v;
    endfunction

    function automatic logic [15:0] aluCompute(input logic [1:0] op, input logic [7:0] b0,
                                               input logic [7:0] b1, input logic [7:0] bLast);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [15:0] dvd;
        logic [15:0] q;
        logic [15:0] r;
        sa = {{8{b0[7]}}, b0};
        sb = {{8{bLast[7]}}, bLast};
        case (op)
            2'b00: return sa + sb;
            2'b01: return sa - sb;
            2'b10: return {8'h00, b0} * {8'h00, bLast};
            default: begin
                if (bLast == 8'h00) return 16'hFFFF;
                dvd = {b0, b1};
                q = dvd / {8'h00, bLast};
                r = dvd % {8'h00, bLast};
                return {q[7:0], r[7:0]};
            end
        endcase
    endfunction

    // Serial ALU: collects op and operand bytes, then returns hi byte with finish, lo byte next
    always @(negedge clk) begin
        if (!rst) begin
            mState <= 0;
            bus.alu_finish <= 1'b0;
            bus.alu_outbus <= 8'h00;
        end else if (bus.alu_start === 1'b1) begin
            mState <= 1;
            mOp <= bus.alu_op;
            mCnt <= 0;
            mNeed <= (bus.alu_op == 2'b11) ? 3 : 2;
            startCount <= startCount + 1;
            lastCount <= 0;
        end else begin
            case (mState)
                1: begin
                    lastBytes[mCnt] <= bus.alu_inbus;
                    lastCount <= mCnt + 1;
                    mCnt <= mCnt + 1;
                    if (mCnt + 1 == mNeed) begin
                        mState <= 2;
                        mDelay <= 2;
                        mRes <= aluCompute(mOp, lastBytes[0], lastBytes[1], bus.alu_inbus);
                    end
                end
                2: begin
                    if (bus.busy !== 1'b1) begin
                        mState <= 0;
                    end else if (!aluHang) begin
                        if (mDelay == 0) begin
                            bus.alu_finish <= 1'b1;
                            bus.alu_outbus <= mRes[15:8];
                            mState <= 3;
                        end else begin
                            mDelay <= mDelay - 1;
                        end
                    end
                end
                3: begin
                    bus.alu_finish <= 1'b0;
                    bus.alu_outbus <= mRes[7:0];
                    mState <= 0;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard: every done pulse pops the oldest expectation
    always @(negedge clk) begin
        if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("done with empty scoreboard", 32'(expQ.size()), 32'd1);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("done client", {bus.done1, bus.done0}, monExp.client ? 2'b10 : 2'b01);
                checkOutput("result", monExp.client ? bus.res1 : bus.res0, monExp.res);
                checkOutput("err", bus.err, monExp.err);
            end
        end
    end

    task automatic holdUntilDone(input logic client, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((client ? bus.done1 : bus.done0) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("client done seen", seen, 1'b1);
        if (client) bus.req1 = 1'b0;
        else        bus.req0 = 1'b0;
    endtask

    task automatic applyStimulus(input logic client, input logic [1:0] op,
                                 input logic [15:0] opa, input logic [7:0] opb);
        @(negedge clk);
        if (client) begin
            bus.op1 = op; bus.opa1 = opa; bus.opb1 = opb; bus.req1 = 1'b1;
        end else begin
            bus.op0 = op; bus.opa0 = opa; bus.opb0 = opb; bus.req0 = 1'b1;
        end
        holdUntilDone(client, 400);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && bus.busy === 1'b0) break;
        end
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic push(input logic c, input logic [15:0] r, input logic e);
        exp_t x;
        x.client = c; x.res = r; x.err = e;
        expQ.push_back(x);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation stopped");
    end

    initial begin
        int     starts;
        logic   early;

        vecs[0] = mkVec(1'b0, OP_ADD, 16'h0005, 8'h03, 16'h0008, 1'b0, 1, 2, 8'h05, 8'h03, 8'h00);
        vecs[1] = mkVec(1'b1, OP_SUB, 16'h0020, 8'h02, 16'h001E, 1'b0, 1, 2, 8'h20, 8'h02, 8'h00);
        vecs[2] = mkVec(1'b0, OP_MUL, 16'h000C, 8'h0A, 16'h0078, 1'b0, 1, 2, 8'h0C, 8'h0A, 8'h00);
        vecs[3] = mkVec(1'b1, OP_DIV, 16'h0064, 8'h07, 16'h0E02, 1'b0, 1, 3, 8'h00, 8'h64, 8'h07);
        vecs[4] = mkVec(1'b0, OP_DIV, 16'h1234, 8'h00, 16'hFFFF, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00);
        vecs[5] = mkVec(1'b1, OP_SUB, 16'h0003, 8'h05, 16'hFFFE, 1'b0, 1, 2, 8'h03, 8'h05, 8'h00);
        vecs[6] = mkVec(1'b0, OP_DIV, 16'h00FF, 8'h10, 16'h0F0F, 1'b0, 1, 3, 8'h00, 8'hFF, 8'h10);
        vecs[7] = mkVec(1'b1, OP_MUL, 16'hABFF, 8'hFF, 16'hFE01, 1'b0, 1, 2, 8'hFF, 8'hFF, 8'h00);

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = 2'b00; bus.op1 = 2'b00;
        bus.opa0 = 16'h0; bus.opa1 = 16'h0;
        bus.opb0 = 8'h0;  bus.opb1 = 8'h0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset ctrl outputs",
                    {bus.done0, bus.done1, bus.err, bus.alu_start, bus.busy, bus.owner, bus.alu_op, bus.alu_inbus}, 32'd0);
        checkOutput("reset res0", bus.res0, 16'h0000);
        checkOutput("reset res1", bus.res1, 16'h0000);
        rst = 1'b1;

        // Simultaneous requests after reset: client 0 first, twice in a row
        for (int rep = 0; rep < 2; rep++) begin
            push(1'b0, 16'h000F, 1'b0);
            push(1'b1, 16'h001E, 1'b0);
            fork
                applyStimulus(1'b0, OP_SUB, 16'h0010, 8'h01);
                applyStimulus(1'b1, OP_SUB, 16'h0020, 8'h02);
            join
            waitIdle(100);
        end

        // Table of single operations
        for (int i = 0; i < 8; i++) begin
            starts = startCount;
            push(vecs[i].client, vecs[i].expRes, vecs[i].expErr);
            applyStimulus(vecs[i].client, vecs[i].op, vecs[i].opa, vecs[i].opb);
            waitIdle(100);
            checkOutput($sformatf("vec%0d alu_start count", i), 32'(startCount - starts), 32'(vecs[i].expStarts));
            if (vecs[i].nBytes > 0) begin
                checkOutput($sformatf("vec%0d byte count", i), 32'(lastCount), 32'(vecs[i].nBytes));
                checkOutput($sformatf("vec%0d byte0", i), lastBytes[0], vecs[i].b0);
                checkOutput($sformatf("vec%0d byte1", i), lastBytes[1], vecs[i].b1);
                if (vecs[i].nBytes == 3)
                    checkOutput($sformatf("vec%0d byte2", i), lastBytes[2], vecs[i].b2);
            end
        end

        // Divide-by-zero: done in the cycle right after the grant, no ALU start
        push(1'b1, 16'hFFFF, 1'b1);
        @(negedge clk);
        bus.op1 = OP_DIV; bus.opa1 = 16'h0042; bus.opb1 = 8'h00; bus.req1 = 1'b1;
        @(negedge clk);
        checkOutput("div0 done timing", bus.done1, 1'b1);
        checkOutput("div0 no start", bus.alu_start, 1'b0);
        checkOutput("div0 busy", bus.busy, 1'b1);
        bus.req1 = 1'b0;
        waitIdle(50);

        // Timeout: start latency, operand bytes, then err/done exactly 16 WAIT cycles later
        aluHang = 1'b1;
        push(1'b0, 16'hFFFF, 1'b1);
        @(negedge clk);
        bus.op0 = OP_SUB; bus.opa0 = 16'h0009; bus.opb0 = 8'h04; bus.req0 = 1'b1;
        @(negedge clk);
        checkOutput("start latency", bus.alu_start, 1'b1);
        checkOutput("start op", bus.alu_op, OP_SUB);
        checkOutput("busy owner", {bus.busy, bus.owner}, 2'b10);
        @(negedge clk);
        checkOutput("opnd1 byte", bus.alu_inbus, 8'h09);
        @(negedge clk);
        checkOutput("opnd2 byte", bus.alu_inbus, 8'h04);
        early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done0 !== 1'b0) early = 1'b1;
            if (k == 5) checkOutput("wait holds last byte", bus.alu_inbus, 8'h04);
        end
        checkOutput("timeout not early", early, 1'b0);
        @(negedge clk);
        checkOutput("timeout done", bus.done0, 1'b1);
        bus.req0 = 1'b0;
        aluHang = 1'b0;
        waitIdle(50);
        push(1'b0, 16'h0078, 1'b0);
        applyStimulus(1'b0, OP_MUL, 16'h000C, 8'h0A);
        waitIdle(100);

        // Reset in WAIT: everything clears, no done, held request is served afterwards
        aluHang = 1'b1;
        @(negedge clk);
        bus.op1 = OP_ADD; bus.opa1 = 16'h0001; bus.opb1 = 8'h01; bus.req1 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid reset ctrl outputs",
                    {bus.done0, bus.done1, bus.err, bus.alu_start, bus.busy, bus.owner, bus.alu_op, bus.alu_inbus}, 32'd0);
        checkOutput("mid reset res0", bus.res0, 16'h0000);
        checkOutput("mid reset res1", bus.res1, 16'h0000);
        rst = 1'b1;
        aluHang = 1'b0;
        push(1'b1, 16'h0002, 1'b0);
        holdUntilDone(1'b1, 100);
        waitIdle(50);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-client arbiter and sequencer for the shared 8-bit serial ALU (add/sub/mul/div). It accepts whole 16/8-bit operation requests from two independent requesters and grants the ALU round-robin. It drives the ALU's start/op/inbus byte protocol, captures the two-byte result from the ALU output bus, and returns it as a 16-bit word to the granted client. It sits between the ALU's top level and the datapath clients.

## Interface

Parameters:
- TIMEOUT, default 255: maximum cycles spent waiting for `alu_finish`. Range 1–255.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req0` / `req1` in 1: client request; held high with stable operands until that client's `done`.
- `op0` / `op1` in 2: operation code; 00 add, 01 sub, 10 mul, 11 div.
- `opa0` / `opa1` in 16: operand A; `[7:0]` for add/sub/mul, full 16-bit dividend for div.
- `opb0` / `opb1` in 8: operand B / divisor.
- `done0` / `done1` out 1: one-cycle completion pulse to the client.
- `res0` / `res1` out 16: result, valid while `done` is high; held until the next `done` to that client.
- `err` out 1: valid with `done`; set on divide-by-zero or timeout.
- `alu_start` out 1: one-cycle ALU start.
- `alu_op` out 2: op to ALU; valid with `alu_start`.
- `alu_inbus` out 8: operand byte to ALU.
- `alu_outbus` in 8: ALU result byte.
- `alu_finish` in 1: ALU result-ready flag.
- `busy` out 1: high from grant until `done`.
- `owner` out 1: granted client index; valid while `busy` is high.

## Operation

- **States:** IDLE, START, OPND1, OPND2, OPND3, WAIT, RES_LO, DONE.
- **IDLE:**
  - If any `req` is high, arbitrate round-robin: the client not served last wins a tie.
  - The last-served pointer resets to 1, so client 0 wins the first tie after reset.
  - Latch op/opa/opb of the winner into internal registers. Later input changes are ignored until `done`.
- **Divide-by-zero:** winner has op=11 and opb=0.
  - Go directly to DONE with `err`=1 and res=16'hFFFF.
  - No `alu_start` is issued.
- **START:** `alu_start`=1, `alu_op`=latched op.
- **Operand bytes, one state per byte, one cycle each:**
  - add/sub/mul: OPND1 drives opa[7:0], OPND2 drives opb.
  - div: OPND1 drives opa[15:8], OPND2 drives opa[7:0], OPND3 drives opb.
- **WAIT:**
  - `alu_inbus` holds the last operand byte.
  - When `alu_finish` is sampled high, capture `alu_outbus` into res[15:8] and go to RES_LO.
  - Watchdog counts WAIT cycles. When it reaches TIMEOUT, go to DONE with `err`=1 and res=16'hFFFF.
- **RES_LO:** capture `alu_outbus` into res[7:0] and go to DONE.
- **Result layout:** add/sub give the sign-extended 16-bit sum/difference; mul gives the 16-bit product; div gives quotient in [15:8] and remainder in [7:0].
- **DONE:**
  - Pulse `done[owner]`, update `res[owner]`, update the last-served pointer, return to IDLE.
  - A request still high in IDLE is arbitrated on the next cycle.
- **Request withdrawal:** a `req` dropped after grant does not abort the operation; `done` still pulses.
- **`err` when both requests are high:** `err` is cleared on every non-error `done`.

## Timing

- **Reset values:** every output is 0; state IDLE; pointer=1; watchdog=0.
- **Reset mid-operation:** all of the above on the next edge. The aborted client gets no `done`. The ALU is reset separately by the top level.
- **Request to start:** a request sampled at edge E0 gives `alu_start` high during cycle E0+1. Operand bytes follow on consecutive cycles with no gaps.
- **Finish to done:** `alu_finish` sampled high at edge Ef gives hi byte captured at Ef, lo byte captured at Ef+1, and `done` high for cycle Ef+1..Ef+2.
- **Divide-by-zero:** `done` is high in the cycle after the grant edge.
- **Back-to-back:** minimum gap between two grants is one IDLE cycle.
- `busy` rises with the grant edge and falls with the edge that ends DONE.

## Structure

- **Package `alu_pkg`:**
  - OP_ADD/OP_SUB/OP_MUL/OP_DIV encodings.
  - State encoding (4-bit, matching the ALU's state-width convention).
  - ERR_RESULT=16'hFFFF.
- **Sub-module `rr_arbiter2`:** two-way round-robin arbiter.
  - Inputs: req[1:0], last pointer. Outputs: grant index, valid.
  - Pointer update is driven by the parent on DONE.

## Test plan

- **Single add:** client 0, op=00, opa=0x0005, opb=0x03. ALU model returns 0x00,0x08 → `alu_inbus` shows 05 then 03; `res0`=0x0008; one `done0` pulse; `done1`=0; `err`=0.
- **Simultaneous requests after reset:** both clients request sub, 0x0010−0x01 and 0x0020−0x02 → client 0 served first (0x000F), then client 1 (0x001E). Repeat → client 0 first again, since the pointer alternates.
- **Divide:** op=11, opa=0x0064, opb=0x07 → inbus 00, 64, 07. ALU returns 0x0E,0x02 → `res`=0x0E02.
- **Divide-by-zero:** op=11, opb=0x00 → no `alu_start`; `done` plus `err`=1 with res=0xFFFF one cycle after grant.
- **Timeout:** TIMEOUT=16; ALU model never raises `finish` → `err`/`done` exactly 16 cycles after entering WAIT. The next request (mul 0x0C×0x0A) completes normally with 0x0078.
- **Reset mid-WAIT:** assert `rst`=0 for one cycle → all outputs 0 the next cycle and no `done`. A held `req` is re-granted after release.
